// File: rtl/down_c_timer_pkg.sv
// Shared types and constants for the down-counting timer.
// State encoding and the default counter width.
package down_c_timer_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

endpackage

// File: rtl/down_c_timer.sv
// Loadable down-counter with one-shot or auto-reload behaviour.
// Emits a one-cycle terminal-count pulse on each 1->0 step.
module down_c_timer
    import down_c_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
        end else if (load) begin
            count  <= load_val;
            reload <= load_val;
            tc     <= 1'b0;
            if (load_val != '0) begin
                state <= RUN;
                busy  <= 1'b1;
            end else begin
                state <= EXPIRED;
                busy  <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
            case (state)
                RUN: begin
                    if (en) begin
                        // zero in RUN only occurs in periodic mode
                        if (count == '0) begin
                            count <= reload;
                        end else if (count == ONE) begin
                            count <= '0;
                            tc    <= 1'b1;
                            if (!periodic) begin
                                state <= EXPIRED;
                                busy  <= 1'b0;
                            end
                        end else begin
                            count <= count - ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_down_c_timer.sv
// Scoreboard bench for down_c_timer (WIDTH=8).
// Stimulus queues expected outputs; a monitor checks them each cycle.
module tb_down_c_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       en = 1'b0;
    logic       periodic = 1'b0;
    logic [7:0] count;
    logic       tc;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [7:0] count;
        logic       tc;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    down_c_timer #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .periodic (periodic),
        .count    (count),
        .tc       (tc),
        .busy     (busy)
    );

    // Monitor: outputs after edge N are compared at the following negedge.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL missed cyc%0d got none want count=%0d",
                         e.cyc, e.count);
            end else if (count !== e.count || tc !== e.tc
                         || busy !== e.busy) begin
                errors++;
                $display("FAIL cyc%0d got count=%0d tc=%0b busy=%0b want count=%0d tc=%0b busy=%0b",
                         cyc, count, tc, busy, e.count, e.tc, e.busy);
            end
        end
    end

    // Apply one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input logic r, input logic l, input logic [7:0] lv,
                        input logic e, input logic p, input logic [7:0] ec,
                        input logic et, input logic eb);
        exp_t x;
        rst      = r;
        load     = l;
        load_val = lv;
        en       = e;
        periodic = p;
        x.cyc    = cyc + 1;
        x.count  = ec;
        x.tc     = et;
        x.busy   = eb;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset overrides a simultaneous load
        step(1, 1, 8'd9, 1, 0, 8'd0, 0, 0);
        step(1, 1, 8'd9, 1, 0, 8'd0, 0, 0);
        // en ignored in IDLE
        step(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // one-shot from 5; periodic wiggled mid-count has no effect
        step(0, 1, 8'd5, 1, 0, 8'd5, 0, 1);
        step(0, 0, 8'd0, 1, 1, 8'd4, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd3, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd2, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd1, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd0, 1, 0);
        step(0, 0, 8'd0, 1, 1, 8'd0, 0, 0);
        step(0, 0, 8'd0, 1, 1, 8'd0, 0, 0);

        // periodic reload of 3: period 4
        step(0, 1, 8'd3, 1, 1, 8'd3, 0, 1);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 8'd0, 1, 1, 8'd2, 0, 1);
            step(0, 0, 8'd0, 1, 1, 8'd1, 0, 1);
            step(0, 0, 8'd0, 1, 1, 8'd0, 1, 1);
            step(0, 0, 8'd0, 1, 1, 8'd3, 0, 1);
        end

        // en pause while parked at zero clears tc and holds
        step(0, 1, 8'd2, 1, 1, 8'd2, 0, 1);
        step(0, 0, 8'd0, 1, 1, 8'd1, 0, 1);
        step(0, 0, 8'd0, 1, 1, 8'd0, 1, 1);
        step(0, 0, 8'd0, 0, 1, 8'd0, 0, 1);
        step(0, 0, 8'd0, 1, 1, 8'd2, 0, 1);

        // en dropped for 2 cycles at count 2
        step(0, 1, 8'd4, 1, 0, 8'd4, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd3, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd2, 0, 1);
        step(0, 0, 8'd0, 0, 0, 8'd2, 0, 1);
        step(0, 0, 8'd0, 0, 0, 8'd2, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd1, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd0, 1, 0);
        step(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // reload at count 1 suppresses tc
        step(0, 1, 8'd2, 1, 0, 8'd2, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd1, 0, 1);
        step(0, 1, 8'd7, 1, 0, 8'd7, 0, 1);
        // full-scale load counts all the way down
        step(0, 1, 8'd255, 1, 0, 8'd255, 0, 1);
        for (int v = 254; v >= 1; v--)
            step(0, 0, 8'd0, 1, 0, 8'(v), 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd0, 1, 0);
        step(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // reset mid-run aborts; then load 0 goes straight to EXPIRED
        step(0, 1, 8'd6, 1, 0, 8'd6, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd5, 0, 1);
        step(0, 0, 8'd0, 1, 0, 8'd4, 0, 1);
        step(1, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        step(0, 1, 8'd0, 1, 0, 8'd0, 0, 0);
        step(0, 0, 8'd0, 1, 1, 8'd0, 0, 0);

        // let the monitor drain, bounded
        for (int t = 0; t < 5 && q.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
